fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of the data path.
REQ-002 SHALL have parameter MAX_BURST, default 16, maximum number of beats per grant (range 1..255).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have ports req0_valid/req1_valid, input, 1, requester has a beat to write.
REQ-006 SHALL have ports req0_data/req1_data, input, DATA_W, requester beat data.
REQ-007 SHALL have ports req0_ready/req1_ready, output, 1, beat accepted this cycle when ANDed with valid.
REQ-008 SHALL have port fifo_full, input, 1, full flag of the downstream synchronous FIFO.
REQ-009 SHALL have port fifo_wr_en, output, 1, FIFO write strobe.
REQ-010 SHALL have port fifo_din, output, DATA_W, FIFO write data.
REQ-011 SHALL have port grant, output, 2, one-hot current owner (01=req0, 10=req1, 00=none).
REQ-012 SHALL have port busy, output, 1, high whenever grant is non-zero.

Function
REQ-013 SHALL implement the states IDLE, GRANT0 and GRANT1 in a registered state machine; grant is decoded from state only.
REQ-014 SHALL drive reqN_ready = (state==GRANTN) & ~fifo_full, combinationally; the non-granted ready SHALL be 0.
REQ-015 SHALL drive fifo_wr_en = reqN_valid & reqN_ready for the granted N, and fifo_din = granted reqN_data, giving zero-cycle latency from accept to FIFO write.
REQ-016 SHALL drive fifo_din to all zeros when no grant is active.
REQ-017 IDLE: if exactly one valid is high, the next state SHALL be that requester's GRANT; if both are high, the next state SHALL be the one not served last (round-robin); if neither is high, remain in IDLE.
REQ-018 SHALL keep an 8-bit beat counter, cleared on every grant entry and incremented on each fifo_wr_en.
REQ-019 A burst SHALL end on the cycle where the beat reaching MAX_BURST is written, or on any cycle where the granted valid is low.
REQ-020 On burst end, if the other requester's valid is high, the next state SHALL be its GRANT directly (no IDLE bubble); otherwise the next state SHALL be IDLE.
REQ-021 While fifo_full is high, no beat SHALL be written, the counter SHALL hold, and the grant SHALL be held even if valid is high (no timeout).
REQ-022 SHALL update last_served to N on every entry to GRANTN.

Reset
REQ-023 On rst, state SHALL be IDLE, beat counter 0, and last_served 1, so req0 wins the first tie.
REQ-024 During reset, grant, busy, fifo_wr_en, req0_ready and req1_ready SHALL be 0 and fifo_din SHALL be 0.
REQ-025 Reset asserted mid-burst SHALL abort the burst immediately; beats not yet accepted are not written.

Configuration
REQ-026 With macro FIFO_WR_ARB_STATS_EN defined, SHALL add outputs beats0 and beats1 (32-bit, wrapping), counting accepted beats per requester and cleared by rst.
REQ-027 Without FIFO_WR_ARB_STATS_EN, those ports and counters SHALL NOT exist; all other behaviour is identical.

Structure
REQ-028 Package fifo_arb_pkg SHALL hold the state encoding (IDLE=0, GRANT0=1, GRANT1=2) and the grant one-hot constants.
REQ-029 Round-robin tie-break SHALL live in sub-module fifo_arb_rr (inputs: two valids, last_served; output: winner index).

Verification
REQ-030 Test 1: req0_valid held for 20 cycles, req1 idle, MAX_BURST=16 -> 16 writes, 1 cycle in IDLE, then GRANT0 again with 4 more writes; fifo_din matches req0_data.
REQ-031 Test 2: both valid continuously from reset -> grants alternate GRANT0,GRANT1,... with 16 beats each and no IDLE cycle between bursts.
REQ-032 Test 3: fifo_full high for 5 cycles mid-burst at beat 7 -> fifo_wr_en=0 and ready=0 for those 5 cycles, grant held, burst resumes at beat 8 and ends at 16.
REQ-033 Test 4: req1 drops valid after 3 beats while req0 is valid -> GRANT0 on the next cycle, last_served=0.
REQ-034 Test 5: rst pulsed during a GRANT1 burst at beat 5 -> all outputs 0 immediately; after release, a tie grants req0 first.
REQ-035 Test 6 (FIFO_WR_ARB_STATS_EN defined): 40 req0 beats and 24 req1 beats -> beats0=40 and beats1=24; build without the macro elaborates with no stats ports.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding and grant constants for the FIFO write arbiter.
package fifo_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } arb_state_t;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_REQ0 = 2'b01;
   localparam logic [1:0] GRANT_REQ1 = 2'b10;

   // One-hot owner decoded purely from the state register.
   function automatic logic [1:0] grant_of(input arb_state_t s);
      case (s)
         GRANT0:  return GRANT_REQ0;
         GRANT1:  return GRANT_REQ1;
         default: return GRANT_NONE;
      endcase
   endfunction

endpackage

// File: rtl/fifo_arb_rr.sv
// fifo_arb_rr: two-way round-robin pick. A lone valid wins outright; on a tie
// the requester that was not served last wins. Only meaningful when a valid is high.
module fifo_arb_rr (
   input  logic i_valid0,
   input  logic i_valid1,
   input  logic i_last_served,
   output logic o_winner
);

   // Winner index: 0 = req0, 1 = req1.
   always_comb begin
      o_winner = 1'b0;
      if (i_valid0 && i_valid1) begin
         o_winner = ~i_last_served;
      end else if (i_valid1) begin
         o_winner = 1'b1;
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: arbitrates two valid/ready writers onto one synchronous FIFO
// write port with bounded bursts (MAX_BURST beats) and round-robin tie-break.
// Optional per-requester beat statistics are enabled by defining FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   input  logic              fifo_full,
   output logic              fifo_wr_en,
   output logic [DATA_W-1:0] fifo_din,
   output logic [1:0]        grant,
`ifdef FIFO_WR_ARB_STATS_EN
   output logic [31:0]       beats0,
   output logic [31:0]       beats1,
`endif
   output logic              busy
);

   localparam logic [7:0] LAST_BEAT_IDX = 8'(MAX_BURST - 1);

   arb_state_t r_state;
   arb_state_t w_state_next;
   logic [7:0] r_beat_cnt;
   logic       r_last_served;
   logic       w_rr_winner;
   logic       w_last_beat;
   logic       w_grant_entry;

   fifo_arb_rr u_rr (
      .i_valid0      (req0_valid),
      .i_valid1      (req1_valid),
      .i_last_served (r_last_served),
      .o_winner      (w_rr_winner)
   );

   assign grant = grant_of(r_state);
   assign busy  = |grant;

   // Handshake and FIFO write path: zero-cycle from accept to write, data muxed by owner.
   always_comb begin
      req0_ready = (r_state == GRANT0) && !fifo_full;
      req1_ready = (r_state == GRANT1) && !fifo_full;
      fifo_wr_en = 1'b0;
      fifo_din   = '0;
      case (r_state)
         GRANT0: begin
            fifo_wr_en = req0_valid && req0_ready;
            fifo_din   = req0_data;
         end
         GRANT1: begin
            fifo_wr_en = req1_valid && req1_ready;
            fifo_din   = req1_data;
         end
         default: begin
            fifo_wr_en = 1'b0;
            fifo_din   = '0;
         end
      endcase
   end

   assign w_last_beat   = fifo_wr_en && (r_beat_cnt == LAST_BEAT_IDX);
   assign w_grant_entry = (w_state_next != IDLE) && (w_state_next != r_state);

   // Next-state: a burst ends on its final beat or when the owner drops valid;
   // a waiting peer takes over directly, otherwise fall back to IDLE.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (req0_valid || req1_valid) begin
               w_state_next = w_rr_winner ? GRANT1 : GRANT0;
            end
         end
         GRANT0: begin
            if (!req0_valid || w_last_beat) begin
               w_state_next = req1_valid ? GRANT1 : IDLE;
            end
         end
         GRANT1: begin
            if (!req1_valid || w_last_beat) begin
               w_state_next = req0_valid ? GRANT0 : IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // State, beat counter (cleared on grant entry, held while full) and last-served owner.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= IDLE;
         r_beat_cnt    <= 8'd0;
         r_last_served <= 1'b1;
      end else begin
         r_state <= w_state_next;
         if (w_grant_entry) begin
            r_beat_cnt    <= 8'd0;
            r_last_served <= (w_state_next == GRANT1);
         end else if (fifo_wr_en) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
         end
      end
   end

`ifdef FIFO_WR_ARB_STATS_EN
   logic [31:0] r_beats0;
   logic [31:0] r_beats1;

   // Wrapping per-requester accepted-beat counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_beats0 <= 32'd0;
         r_beats1 <= 32'd0;
      end else begin
         if (req0_valid && req0_ready) begin
            r_beats0 <= r_beats0 + 32'd1;
         end
         if (req1_valid && req1_ready) begin
            r_beats1 <= r_beats1 + 32'd1;
         end
      end
   end

   assign beats0 = r_beats0;
   assign beats1 = r_beats1;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed tests for fifo_wr_arbiter (MAX_BURST=16, DATA_W=8).
// Stats checks are compiled in when FIFO_WR_ARB_STATS_EN is defined.
module tb_fifo_wr_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0_valid = 1'b0;
   logic       req1_valid = 1'b0;
   logic [7:0] req0_data = 8'h00;
   logic [7:0] req1_data = 8'h00;
   logic       fifo_full = 1'b0;
   logic       req0_ready;
   logic       req1_ready;
   logic       fifo_wr_en;
   logic [7:0] fifo_din;
   logic [1:0] grant;
   logic       busy;
`ifdef FIFO_WR_ARB_STATS_EN
   logic [31:0] beats0;
   logic [31:0] beats1;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.DATA_W(8), .MAX_BURST(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .fifo_full  (fifo_full),
      .fifo_wr_en (fifo_wr_en),
      .fifo_din   (fifo_din),
      .grant      (grant),
`ifdef FIFO_WR_ARB_STATS_EN
      .beats0     (beats0),
      .beats1     (beats1),
`endif
      .busy       (busy)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // One cycle: sample at negedge against hand-computed values, then step to posedge+1.
   task automatic cyc(input string tag, input logic [1:0] eg, input logic ew, input logic [7:0] ed);
      @(negedge clk);
      $display("cyc %-10s grant=%b wr=%b din=%02h full=%b rst=%b", tag, grant, fifo_wr_en, fifo_din, fifo_full, rst);
      check_val({tag, " grant"}, 32'(grant), 32'(eg));
      check_val({tag, " wr_en"}, 32'(fifo_wr_en), 32'(ew));
      check_val({tag, " din"}, 32'(fifo_din), 32'(ed));
      check_val({tag, " busy"}, 32'(busy), 32'(eg != 2'b00));
      check_val({tag, " rdy0"}, 32'(req0_ready), 32'((eg == 2'b01) && !fifo_full));
      check_val({tag, " rdy1"}, 32'(req1_ready), 32'((eg == 2'b10) && !fifo_full));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst        = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      fifo_full  = 1'b0;
      req0_data  = 8'h55;
      req1_data  = 8'hAA;
      cyc("rst_a", 2'b00, 1'b0, 8'h00);
      cyc("rst_b", 2'b00, 1'b0, 8'h00);
      rst        = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   initial begin
      logic [7:0] d0;
      logic [7:0] d1;
      int n0, n1, nw, last_c;

      // Test 1: single requester, 20 beats -> 16, one IDLE cycle, 4 more.
      do_reset();
      req0_valid = 1'b1;
      req0_data  = 8'h00;
      cyc("t1_idle", 2'b00, 1'b0, 8'h00);
      for (int k = 0; k < 16; k++) begin
         req0_data = 8'(k);
         cyc("t1_beat", 2'b01, 1'b1, 8'(k));
      end
      req0_data = 8'd16;
      cyc("t1_gap", 2'b00, 1'b0, 8'h00);
      for (int k = 16; k < 20; k++) begin
         req0_data = 8'(k);
         cyc("t1_beat2", 2'b01, 1'b1, 8'(k));
      end
      req0_valid = 1'b0;
      req0_data  = 8'd20;
      cyc("t1_drop", 2'b01, 1'b0, 8'd20);
      cyc("t1_end", 2'b00, 1'b0, 8'h00);

      // Test 2: both valid from reset -> G0,G1,G0 bursts of 16, no IDLE between.
      do_reset();
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      d0 = 8'h00;
      d1 = 8'h80;
      req0_data = d0;
      req1_data = d1;
      cyc("t2_idle", 2'b00, 1'b0, 8'h00);
      for (int b = 0; b < 3; b++) begin
         for (int k = 0; k < 16; k++) begin
            if (b % 2 == 0) begin
               req0_data = d0;
               cyc("t2_g0", 2'b01, 1'b1, d0);
               d0 = d0 + 8'd1;
            end else begin
               req1_data = d1;
               cyc("t2_g1", 2'b10, 1'b1, d1);
               d1 = d1 + 8'd1;
            end
         end
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req1_data  = d1;
      cyc("t2_drop", 2'b10, 1'b0, d1);
      cyc("t2_end", 2'b00, 1'b0, 8'h00);

      // Test 3: FIFO full for 5 cycles after 7 beats; burst still totals 16.
      do_reset();
      req0_valid = 1'b1;
      cyc("t3_idle", 2'b00, 1'b0, 8'h00);
      for (int k = 0; k < 7; k++) begin
         req0_data = 8'(k);
         cyc("t3_beat", 2'b01, 1'b1, 8'(k));
      end
      fifo_full = 1'b1;
      req0_data = 8'd7;
      for (int k = 0; k < 5; k++) begin
         cyc("t3_full", 2'b01, 1'b0, 8'd7);
      end
      fifo_full = 1'b0;
      for (int k = 7; k < 16; k++) begin
         req0_data = 8'(k);
         cyc("t3_resume", 2'b01, 1'b1, 8'(k));
      end
      cyc("t3_gap", 2'b00, 1'b0, 8'h00);

      // Test 4: req1 drops after 3 beats -> GRANT0 next; later tie goes to req1.
      do_reset();
      req1_valid = 1'b1;
      req1_data  = 8'h80;
      cyc("t4_idle", 2'b00, 1'b0, 8'h00);
      req0_valid = 1'b1;
      req0_data  = 8'h00;
      for (int k = 0; k < 3; k++) begin
         req1_data = 8'h80 + 8'(k);
         cyc("t4_g1", 2'b10, 1'b1, 8'h80 + 8'(k));
      end
      req1_valid = 1'b0;
      req1_data  = 8'h83;
      cyc("t4_drop1", 2'b10, 1'b0, 8'h83);
      cyc("t4_g0", 2'b01, 1'b1, 8'h00);
      req0_valid = 1'b0;
      req0_data  = 8'h01;
      cyc("t4_drop0", 2'b01, 1'b0, 8'h01);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      cyc("t4_idle2", 2'b00, 1'b0, 8'h00);
      req1_data = 8'h90;
      cyc("t4_rr", 2'b10, 1'b1, 8'h90);

      // Test 5: reset in the middle of a GRANT1 burst, then tie favours req0.
      do_reset();
      req1_valid = 1'b1;
      cyc("t5_idle", 2'b00, 1'b0, 8'h00);
      for (int k = 0; k < 5; k++) begin
         req1_data = 8'hA0 + 8'(k);
         cyc("t5_g1", 2'b10, 1'b1, 8'hA0 + 8'(k));
      end
      rst        = 1'b1;
      req0_valid = 1'b1;
      req1_data  = 8'hA5;
      cyc("t5_rst", 2'b00, 1'b0, 8'h00);
      rst = 1'b0;
      cyc("t5_idle2", 2'b00, 1'b0, 8'h00);
      req0_data = 8'h11;
      cyc("t5_tie", 2'b01, 1'b1, 8'h11);

      // Test 6: 40 req0 beats and 24 req1 beats; last write lands on cycle 65.
      do_reset();
      n0 = 0;
      n1 = 0;
      nw = 0;
      last_c = -1;
      for (int c = 0; c < 120; c++) begin
         req0_valid = (n0 < 40);
         req1_valid = (n1 < 24);
         req0_data  = 8'(n0);
         req1_data  = 8'h80 + 8'(n1);
         @(negedge clk);
         if (fifo_wr_en) begin
            $display("t6 c=%0d grant=%b din=%02h", c, grant, fifo_din);
            nw++;
            last_c = c;
            if (grant == 2'b01) begin
               check_val("t6_din0", 32'(fifo_din), 32'(req0_data));
               n0++;
            end else begin
               check_val("t6_din1", 32'(fifo_din), 32'(req1_data));
               n1++;
            end
         end
         @(posedge clk);
         #1;
      end
      check_val("t6_n0", n0, 32'd40);
      check_val("t6_n1", n1, 32'd24);
      check_val("t6_writes", nw, 32'd64);
      check_val("t6_last_cycle", last_c, 32'd65);
`ifdef FIFO_WR_ARB_STATS_EN
      check_val("t6_beats0", beats0, 32'd40);
      check_val("t6_beats1", beats1, 32'd24);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
